gpr_scoreboard: RTL and testbench

In-order GPR write scoreboard for the single-issue pipeline. It records the destination register of every issued instruction that writes a GPR, and retires entries as the WBU writes them back. It tells the decode stage to stall when a source register still has a write pending. This replaces single-stage EXU-only RAW detection, so that multi-cycle LSU and MDU results are covered.

---
 rtl/gpr_scoreboard_pkg.sv | 11 +
 rtl/gpr_scoreboard.sv | 124 ++++++++++++
 tb/tb_gpr_scoreboard.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/gpr_scoreboard_pkg.sv
// Shared constants and types for the in-order GPR write scoreboard.
package gpr_scoreboard_pkg;

    localparam int unsigned GPR_IDX_W         = 5;
    localparam int unsigned SCB_DEPTH_DEFAULT = 4;

    typedef logic [GPR_IDX_W-1:0] gpr_idx_t;

    localparam gpr_idx_t GPR_ZERO = 5'd0;

endpackage

// File: rtl/gpr_scoreboard.sv
// In-order GPR write scoreboard: tracks pending destination registers of issued
// instructions and raises a RAW stall toward decode until writeback retires them.
module gpr_scoreboard
    import gpr_scoreboard_pkg::*;
#(
    parameter int unsigned DEPTH     = SCB_DEPTH_DEFAULT,
    parameter bit          WB_BYPASS = 1'b1,
    localparam int unsigned PTR_W    = $clog2(DEPTH),
    localparam int unsigned CNT_W    = PTR_W + 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [GPR_IDX_W-1:0] rs1,
    input  logic                 rs1_used,
    input  logic [GPR_IDX_W-1:0] rs2,
    input  logic                 rs2_used,
    output logic                 stall,
    input  logic                 issue_valid,
    input  logic [GPR_IDX_W-1:0] issue_rd,
    output logic                 issue_ready,
    input  logic                 wb_valid,
    input  logic [GPR_IDX_W-1:0] wb_rd,
    input  logic                 flush,
    output logic [CNT_W-1:0]     count,
    output logic                 empty
);

    logic [GPR_IDX_W-1:0] rd_q [DEPTH];
    logic [PTR_W-1:0]     head_q, head_d;
    logic [PTR_W-1:0]     tail_q, tail_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic                 empty_q, empty_d;
    logic                 ready_q, ready_d;

    logic                 push;
    logic                 pop;
    logic                 bypass_head;
    logic [DEPTH-1:0]     valid_mask;
    logic [DEPTH-1:0]     match1_mask;
    logic [DEPTH-1:0]     match2_mask;
    logic                 hit1;
    logic                 hit2;

    // Registered ready gates the push, so a same-cycle pop never frees a slot early.
    assign push = issue_valid && ready_q && (issue_rd != GPR_ZERO) && !flush;
    assign pop  = wb_valid && !empty_q && !flush;

    // The retiring head is forwarded by the regfile, so it no longer blocks decode.
    assign bypass_head = WB_BYPASS && wb_valid;

    // Per-entry occupancy and source compares.
    for (genvar i = 0; i < DEPTH; i++) begin : g_entry
        logic [PTR_W-1:0] age;
        logic             is_head;

        assign age            = PTR_W'(i) - head_q;
        assign is_head        = (PTR_W'(i) == head_q);
        assign valid_mask[i]  = (CNT_W'(age) < count_q) && !(bypass_head && is_head);
        assign match1_mask[i] = valid_mask[i] && (rd_q[i] == rs1);
        assign match2_mask[i] = valid_mask[i] && (rd_q[i] == rs2);
    end

    assign hit1  = (rs1 != GPR_ZERO) && (|match1_mask);
    assign hit2  = (rs2 != GPR_ZERO) && (|match2_mask);
    assign stall = (rs1_used && hit1) || (rs2_used && hit2);

    // Next-state: flush drops everything still in flight, including a same-cycle push.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;

        if (flush) begin
            head_d  = tail_q;
            count_d = '0;
        end else begin
            if (push) begin
                tail_d = tail_q + PTR_W'(1);
            end
            if (pop) begin
                head_d = head_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end

        empty_d = (count_d == '0);
        ready_d = (count_d != CNT_W'(DEPTH));
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            empty_q <= 1'b1;
            ready_q <= 1'b1;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                rd_q[i] <= GPR_ZERO;
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            empty_q <= empty_d;
            ready_q <= ready_d;
            if (push) begin
                rd_q[tail_q] <= issue_rd;
            end
        end
    end

    // Writebacks must retire in program order against a non-empty scoreboard.
    always_ff @(posedge clock) begin
        if (!reset && wb_valid) begin
            assert (!empty_q && (rd_q[head_q] == wb_rd))
                else $error("gpr_scoreboard: writeback rd %0d does not match oldest pending write", wb_rd);
        end
    end

    assign count       = count_q;
    assign empty       = empty_q;
    assign issue_ready = ready_q;

endmodule

// File: tb/tb_gpr_scoreboard.sv
// Directed bench for gpr_scoreboard: stimulus queues expected outputs per cycle,
// an independent monitor compares them on the falling edge.
module tb_gpr_scoreboard;

    logic       clock;
    logic       reset;
    logic [4:0] rs1;
    logic       rs1_used;
    logic [4:0] rs2;
    logic       rs2_used;
    logic       stall;
    logic       issue_valid;
    logic [4:0] issue_rd;
    logic       issue_ready;
    logic       wb_valid;
    logic [4:0] wb_rd;
    logic       flush;
    logic [2:0] count;
    logic       empty;

    gpr_scoreboard #(
        .DEPTH    (4),
        .WB_BYPASS(1'b1)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .rs1        (rs1),
        .rs1_used   (rs1_used),
        .rs2        (rs2),
        .rs2_used   (rs2_used),
        .stall      (stall),
        .issue_valid(issue_valid),
        .issue_rd   (issue_rd),
        .issue_ready(issue_ready),
        .wb_valid   (wb_valid),
        .wb_rd      (wb_rd),
        .flush      (flush),
        .count      (count),
        .empty      (empty)
    );

    typedef struct {
        int unsigned cyc;
        string       name;
        logic        stall;
        logic [2:0]  count;
        logic        empty;
        logic        ready;
    } exp_t;

    exp_t        exp_q[$];
    int unsigned cyc    = 0;
    int          checks = 0;
    int          passed = 0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Monitor: compare every expectation scheduled for the current cycle.
    always @(negedge clock) begin
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            exp_t e;
            e = exp_q.pop_front();
            checks++;
            if (e.cyc != cyc) begin
                $display("FAIL %s: expectation for cycle %0d missed (now %0d)", e.name, e.cyc, cyc);
            end else if (stall !== e.stall || count !== e.count ||
                         empty !== e.empty || issue_ready !== e.ready) begin
                $display("FAIL %s: got stall=%b count=%0d empty=%b ready=%b, want stall=%b count=%0d empty=%b ready=%b",
                         e.name, stall, count, empty, issue_ready, e.stall, e.count, e.empty, e.ready);
            end else begin
                passed++;
            end
        end
    end

    task automatic idle();
        rs1 = 5'd0; rs1_used = 1'b0; rs2 = 5'd0; rs2_used = 1'b0;
        issue_valid = 1'b0; issue_rd = 5'd0;
        wb_valid = 1'b0; wb_rd = 5'd0; flush = 1'b0;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic expect_now(input string name, input logic s, input logic [2:0] c,
                              input logic e, input logic r);
        exp_t x;
        x.cyc = cyc; x.name = name; x.stall = s; x.count = c; x.empty = e; x.ready = r;
        exp_q.push_back(x);
    endtask

    task automatic issue(input logic [4:0] rd);
        idle();
        issue_valid = 1'b1; issue_rd = rd;
        tick();
    endtask

    task automatic wb(input logic [4:0] rd);
        idle();
        wb_valid = 1'b1; wb_rd = rd;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        idle();
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        expect_now("reset", 1'b0, 3'd0, 1'b1, 1'b1);
        tick();

        // Single writer, then bypassed retire.
        issue(5'd5);
        idle(); rs1 = 5'd5; rs1_used = 1'b1;
        expect_now("raw_after_issue", 1'b1, 3'd1, 1'b0, 1'b1);
        tick();
        idle(); rs1 = 5'd5; rs1_used = 1'b1; wb_valid = 1'b1; wb_rd = 5'd5;
        expect_now("bypass_same_cycle", 1'b0, 3'd1, 1'b0, 1'b1);
        tick();
        idle(); rs1 = 5'd5; rs1_used = 1'b1;
        expect_now("pop_done", 1'b0, 3'd0, 1'b1, 1'b1);
        tick();

        // rd=0 is never recorded.
        issue(5'd0);
        idle(); rs1 = 5'd0; rs1_used = 1'b1;
        expect_now("rd0_not_recorded", 1'b0, 3'd0, 1'b1, 1'b1);
        tick();

        // Fill, then pop+push while full: the push must be refused.
        issue(5'd3); issue(5'd4); issue(5'd5); issue(5'd6);
        idle(); rs1 = 5'd6; rs1_used = 1'b1;
        expect_now("full", 1'b1, 3'd4, 1'b0, 1'b0);
        tick();
        idle(); wb_valid = 1'b1; wb_rd = 5'd3; issue_valid = 1'b1; issue_rd = 5'd8;
        expect_now("full_pushpop_cycle", 1'b0, 3'd4, 1'b0, 1'b0);
        tick();
        idle(); rs1 = 5'd8; rs1_used = 1'b1;
        expect_now("push_blocked_when_full", 1'b0, 3'd3, 1'b0, 1'b1);
        tick();
        idle(); rs1 = 5'd8; rs1_used = 1'b1; rs2 = 5'd4; rs2_used = 1'b1;
        expect_now("older_entry_still_hits", 1'b1, 3'd3, 1'b0, 1'b1);
        tick();
        idle(); rs2 = 5'd4; rs2_used = 1'b0;
        expect_now("unused_source_ignored", 1'b0, 3'd3, 1'b0, 1'b1);
        tick();
        wb(5'd4); wb(5'd5); wb(5'd6);
        idle(); rs1 = 5'd6; rs1_used = 1'b1;
        expect_now("drained", 1'b0, 3'd0, 1'b1, 1'b1);
        tick();

        // Duplicate destinations keep the hazard until the last one retires.
        issue(5'd7); issue(5'd7);
        idle(); rs2 = 5'd7; rs2_used = 1'b1; wb_valid = 1'b1; wb_rd = 5'd7;
        expect_now("dup_first_pop", 1'b1, 3'd2, 1'b0, 1'b1);
        tick();
        idle(); rs2 = 5'd7; rs2_used = 1'b1; wb_valid = 1'b1; wb_rd = 5'd7;
        expect_now("dup_second_pop", 1'b0, 3'd1, 1'b0, 1'b1);
        tick();
        idle(); rs2 = 5'd7; rs2_used = 1'b1;
        expect_now("dup_cleared", 1'b0, 3'd0, 1'b1, 1'b1);
        tick();

        // Flush with a concurrent issue: everything dropped.
        issue(5'd1); issue(5'd2); issue(5'd10);
        idle(); flush = 1'b1; issue_valid = 1'b1; issue_rd = 5'd9;
        expect_now("flush_cycle", 1'b0, 3'd3, 1'b0, 1'b1);
        tick();
        idle(); rs1 = 5'd9; rs1_used = 1'b1; rs2 = 5'd1; rs2_used = 1'b1;
        expect_now("flush_clears", 1'b0, 3'd0, 1'b1, 1'b1);
        tick();

        // Ten push/pop pairs walk the pointers around the ring twice.
        issue(5'd11);
        for (int k = 0; k < 10; k++) begin
            idle();
            issue_valid = 1'b1; issue_rd = 5'(12 + k);
            wb_valid = 1'b1;    wb_rd = 5'(11 + k);
            rs1 = 5'(12 + k); rs1_used = 1'b1;
            rs2 = 5'(11 + k); rs2_used = 1'b1;
            expect_now($sformatf("wrap_pair_%0d", k), 1'b0, 3'd1, 1'b0, 1'b1);
            tick();
        end
        idle(); rs1 = 5'd21; rs1_used = 1'b1;
        expect_now("wrap_final_hit", 1'b1, 3'd1, 1'b0, 1'b1);
        tick();
        idle(); rs1 = 5'd21; rs1_used = 1'b1; wb_valid = 1'b1; wb_rd = 5'd21;
        expect_now("wrap_final_bypass", 1'b0, 3'd1, 1'b0, 1'b1);
        tick();
        idle(); rs1 = 5'd20; rs1_used = 1'b1;
        expect_now("wrap_drained", 1'b0, 3'd0, 1'b1, 1'b1);
        tick();

        idle();
        repeat (2) @(posedge clock);
        if (exp_q.size() != 0) begin
            checks++;
            $display("FAIL leftover: %0d expectations never compared, want 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
